// File: rtl/axis_pkg.sv
// Shared definitions for the stream upsizer: FSM state encoding and the
// lane counter width helper.
package axis_pkg;

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

    // A lane counter needs clog2(ratio) bits, but never fewer than one.
    function automatic int cnt_width(input int r);
        return (r < 2) ? 1 : $clog2(r);
    endfunction

endpackage

// File: rtl/axis_upsizer_if.sv
// Narrow input stream plus wide framed output stream of the upsizer.
// The slave modport is the upsizer itself, the master modport drives it.
interface axis_upsizer_if #(
    parameter int width = 8,
    parameter int ratio = 4
);
    logic [width-1:0]       up_data;
    logic                   up_valid;
    logic                   up_last;
    logic                   up_ready;
    logic [width*ratio-1:0] down_data;
    logic [ratio-1:0]       down_keep;
    logic                   down_last;
    logic                   down_valid;
    logic                   down_ready;

    modport slave (
        input  up_data, up_valid, up_last, down_ready,
        output up_ready, down_data, down_keep, down_last, down_valid
    );

    modport master (
        output up_data, up_valid, up_last, down_ready,
        input  up_ready, down_data, down_keep, down_last, down_valid
    );
endinterface

// File: rtl/axis_upsizer.sv
// Packs ratio consecutive width-bit beats into one wide beat with a lane keep
// mask; up_last closes a word early. One word can wait in the accumulator
// (HOLD) while the output register is still occupied.
module axis_upsizer
    import axis_pkg::*;
#(
    parameter int width = 8,
    parameter int ratio = 4
) (
    input logic           clk,
    input logic           rst,
    axis_upsizer_if.slave bus
);
    localparam int CW = cnt_width(ratio);

    state_t                 state;
    state_t                 state_next;
    logic [width*ratio-1:0] acc;
    logic [ratio-1:0]       acc_keep;
    logic                   acc_last;
    logic [CW-1:0]          cnt;
    logic [width*ratio-1:0] out_data;
    logic [ratio-1:0]       out_keep;
    logic                   out_last;
    logic                   out_valid;

    logic                   out_free;
    logic                   beat_ends;
    logic [width*ratio-1:0] merged_data;
    logic [ratio-1:0]       merged_keep;
    logic                   take_beat;
    logic                   load_direct;
    logic                   park_word;
    logic                   release_word;

    assign out_free  = !out_valid || bus.down_ready;
    assign beat_ends = (cnt == CW'(ratio - 1)) || bus.up_last;

    // Accumulator with the incoming beat dropped into lane cnt.
    always_comb begin
        merged_data = acc;
        merged_keep = acc_keep;
        merged_data[int'(cnt)*width +: width] = bus.up_data;
        merged_keep[cnt] = 1'b1;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= COLLECT;
        else     state <= state_next;
    end

    // Next state and datapath control; up_ready depends on state only.
    always_comb begin
        state_next   = state;
        bus.up_ready = 1'b0;
        take_beat    = 1'b0;
        load_direct  = 1'b0;
        park_word    = 1'b0;
        release_word = 1'b0;
        case (state)
            COLLECT: begin
                bus.up_ready = 1'b1;
                if (bus.up_valid) begin
                    if (!beat_ends) begin
                        take_beat = 1'b1;
                    end else if (out_free) begin
                        load_direct = 1'b1;
                    end else begin
                        park_word  = 1'b1;
                        state_next = HOLD;
                    end
                end
            end
            HOLD: begin
                if (out_free) begin
                    release_word = 1'b1;
                    state_next   = COLLECT;
                end
            end
            default: state_next = COLLECT;
        endcase
    end

    // Accumulator, lane counter and output register updates.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc       <= '0;
            acc_keep  <= '0;
            acc_last  <= 1'b0;
            cnt       <= '0;
            out_data  <= '0;
            out_keep  <= '0;
            out_last  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            if (out_valid && bus.down_ready) out_valid <= 1'b0;
            if (take_beat) begin
                acc      <= merged_data;
                acc_keep <= merged_keep;
                cnt      <= cnt + CW'(1);
            end
            if (park_word) begin
                acc      <= merged_data;
                acc_keep <= merged_keep;
                acc_last <= bus.up_last;
            end
            if (load_direct) begin
                out_data  <= merged_data;
                out_keep  <= merged_keep;
                out_last  <= bus.up_last;
                out_valid <= 1'b1;
                acc       <= '0;
                acc_keep  <= '0;
                acc_last  <= 1'b0;
                cnt       <= '0;
            end
            if (release_word) begin
                out_data  <= acc;
                out_keep  <= acc_keep;
                out_last  <= acc_last;
                out_valid <= 1'b1;
                acc       <= '0;
                acc_keep  <= '0;
                acc_last  <= 1'b0;
                cnt       <= '0;
            end
        end
    end

    assign bus.down_data  = out_data;
    assign bus.down_keep  = out_keep;
    assign bus.down_last  = out_last;
    assign bus.down_valid = out_valid;

endmodule

// File: tb/tb_axis_upsizer.sv
// Bench for axis_upsizer: directed packets then random traffic, all checked
// against a queue-of-words model built from the packing rules.
module tb_axis_upsizer;
    localparam int W = 8;
    localparam int R = 4;

    typedef struct {
        logic [W*R-1:0] data;
        logic [R-1:0]   keep;
        logic           last;
    } word_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checkCount = 0;
    int   failCount  = 0;
    bit   modelLive  = 1'b0;
    bit   randomReady = 1'b0;

    word_t          expQ[$];
    logic [W-1:0]   curBeats[$];

    axis_upsizer_if #(.width(W), .ratio(R)) bus ();

    axis_upsizer #(.width(W), .ratio(R)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h at %0t",
                     tag, observed, expected, $time);
        end
    endtask

    // Reference model: words complete after ratio beats or on last; at most
    // two completed words can be waiting, and input stalls only then.
    always @(negedge clk) begin
        if (modelLive) begin
            checkOutput("up_ready", 64'(bus.up_ready), 64'(expQ.size() < 2));
            checkOutput("down_valid", 64'(bus.down_valid), 64'(expQ.size() > 0));
            if (expQ.size() > 0 && bus.down_valid === 1'b1) begin
                checkOutput("down_data", 64'(bus.down_data), 64'(expQ[0].data));
                checkOutput("down_keep", 64'(bus.down_keep), 64'(expQ[0].keep));
                checkOutput("down_last", 64'(bus.down_last), 64'(expQ[0].last));
            end
        end
        if (rst) begin
            expQ.delete();
            curBeats.delete();
            modelLive = 1'b1;
        end else if (modelLive) begin
            if (bus.down_valid === 1'b1 && bus.down_ready && expQ.size() > 0)
                void'(expQ.pop_front());
            if (bus.up_valid && bus.up_ready === 1'b1) begin
                curBeats.push_back(bus.up_data);
                if (curBeats.size() == R || bus.up_last) begin
                    word_t w;
                    w.data = '0;
                    w.keep = '0;
                    w.last = bus.up_last;
                    for (int i = 0; i < curBeats.size(); i++) begin
                        w.data = w.data | ((W*R)'(curBeats[i]) << (i * W));
                        w.keep[i] = 1'b1;
                    end
                    expQ.push_back(w);
                    curBeats.delete();
                end
            end
        end
    end

    // Random backpressure while the random phase is active.
    always @(posedge clk) begin
        #1;
        if (randomReady) bus.down_ready = ($urandom_range(0, 3) != 0);
    end

    // Hard stop in case something wedges.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idleBus();
        bus.up_valid = 1'b0;
        bus.up_last  = 1'b0;
        bus.up_data  = W'($urandom);
    endtask

    // Present one beat and hold it until the edge that accepts it.
    task automatic applyStimulus(input logic [W-1:0] data, input logic last);
        bit ok;
        int waited;
        bus.up_data  = data;
        bus.up_last  = last;
        bus.up_valid = 1'b1;
        ok = 1'b0;
        waited = 0;
        while (!ok && waited < 64) begin
            @(negedge clk);
            ok = (bus.up_ready === 1'b1);
            @(posedge clk);
            #1;
            waited++;
        end
        if (!ok) checkOutput("send_timeout", 64'(ok), 64'd1);
    endtask

    task automatic checkWordNow(input string tag, input logic [W*R-1:0] data,
                                input logic [R-1:0] keep, input logic last);
        @(negedge clk);
        checkOutput({tag, "_valid"}, 64'(bus.down_valid), 64'd1);
        checkOutput({tag, "_data"}, 64'(bus.down_data), 64'(data));
        checkOutput({tag, "_keep"}, 64'(bus.down_keep), 64'(keep));
        checkOutput({tag, "_last"}, 64'(bus.down_last), 64'(last));
    endtask

    initial begin
        bus.down_ready = 1'b1;
        idleBus();
        repeat (3) nextCycle();
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_valid", 64'(bus.down_valid), 64'd0);
        checkOutput("rst_data", 64'(bus.down_data), 64'd0);
        checkOutput("rst_keep", 64'(bus.down_keep), 64'd0);
        checkOutput("rst_last", 64'(bus.down_last), 64'd0);
        checkOutput("rst_ready", 64'(bus.up_ready), 64'd1);
        nextCycle();

        $display("[TB] full packet word");
        applyStimulus(8'h11, 1'b0);
        applyStimulus(8'h22, 1'b0);
        applyStimulus(8'h33, 1'b0);
        applyStimulus(8'h44, 1'b1);
        idleBus();
        checkWordNow("full", 32'h44332211, 4'b1111, 1'b1);
        nextCycle();

        $display("[TB] partial and single-lane words");
        applyStimulus(8'hA1, 1'b0);
        applyStimulus(8'hA2, 1'b1);
        idleBus();
        checkWordNow("two_lane", 32'h0000A2A1, 4'b0011, 1'b1);
        nextCycle();
        applyStimulus(8'h5C, 1'b1);
        idleBus();
        checkWordNow("one_lane", 32'h0000005C, 4'b0001, 1'b1);
        nextCycle();

        $display("[TB] backpressure into hold");
        bus.down_ready = 1'b0;
        for (int i = 1; i <= 8; i++) applyStimulus(W'(i), 1'b0);
        idleBus();
        checkWordNow("held", 32'h04030201, 4'b1111, 1'b0);
        checkOutput("hold_ready", 64'(bus.up_ready), 64'd0);
        nextCycle();
        checkWordNow("still_held", 32'h04030201, 4'b1111, 1'b0);
        nextCycle();
        bus.down_ready = 1'b1;
        checkWordNow("drain_first", 32'h04030201, 4'b1111, 1'b0);
        nextCycle();
        checkWordNow("drain_second", 32'h08070605, 4'b1111, 1'b0);
        checkOutput("ready_back", 64'(bus.up_ready), 64'd1);
        nextCycle();

        $display("[TB] continuous stream");
        for (int i = 0; i < 16; i++) applyStimulus(W'(8'hC0 + i), 1'b0);
        idleBus();
        repeat (2) nextCycle();

        $display("[TB] reset mid-word");
        applyStimulus(8'hE0, 1'b0);
        applyStimulus(8'hE1, 1'b0);
        idleBus();
        rst = 1'b1;
        nextCycle();
        rst = 1'b0;
        @(negedge clk);
        checkOutput("midrst_valid", 64'(bus.down_valid), 64'd0);
        nextCycle();
        for (int i = 0; i < 4; i++) applyStimulus(W'(8'hB0 + i), 1'b0);
        idleBus();
        checkWordNow("after_rst", 32'hB3B2B1B0, 4'b1111, 1'b0);
        nextCycle();

        $display("[TB] random traffic");
        randomReady = 1'b1;
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                idleBus();
                repeat ($urandom_range(1, 3)) nextCycle();
            end
            applyStimulus(W'($urandom), ($urandom_range(0, 4) == 0));
        end
        idleBus();
        randomReady = 1'b0;
        bus.down_ready = 1'b1;
        repeat (10) nextCycle();
        @(negedge clk);
        checkOutput("drained", 64'(expQ.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checkCount, failCount);
        $finish;
    end
endmodule

// File: doc/axis_upsizer.md
Name: axis_upsizer

Overview:
- Downstream stage of the stream FIFO wrapper: consumes its width-bit valid/ready output and packs `ratio` consecutive beats into one wide beat.
- Adds packet framing. `up_last` closes a word early, producing a partial word with a lane-keep mask.
- Sustains one wide output beat per `ratio` input beats with no bubbles. `up_ready` is a registered-state function only and never depends combinationally on `down_ready` or `up_valid`.

Parameters:
- width, 8, bits per input beat (lane width)
- ratio, 4, input beats per output word; legal range 2..16

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- up_data  input  width  input beat data
- up_valid  input  1  input beat valid
- up_last  input  1  input beat is the final beat of a packet
- up_ready  output  1  block accepts an input beat this cycle
- down_data  output  width*ratio  packed word; lane i is bits [i*width +: width]
- down_keep  output  ratio  bit i set means lane i holds valid data
- down_last  output  1  word ends a packet
- down_valid  output  1  output word valid
- down_ready  input  1  downstream accepts word

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high. All state updates occur on the rising clk edge.
- Handshakes:
  - Input transfer: up_valid & up_ready.
  - Output transfer: down_valid & down_ready.
  - Once down_valid is asserted, down_data, down_keep and down_last stay stable until the transfer.
- Datapath: accumulator register acc (width*ratio), keep register acc_keep, last flag acc_last, lane counter cnt (clog2(ratio) bits), and output register.
- State machine (package enum): COLLECT, HOLD.
  - COLLECT: up_ready = 1. An accepted beat writes lane cnt of acc and sets acc_keep[cnt].
  - Completing beat: cnt == ratio-1, or up_last = 1.
    - On a non-completing beat: cnt increments.
    - On a completing beat with the output register free (down_valid = 0, or down_ready = 1 this cycle): load the output register directly from acc merged with the incoming beat, then clear acc, acc_keep and cnt. State stays COLLECT.
    - On a completing beat with the output register busy: store the completed word in acc, set acc_last = up_last, and go to HOLD.
  - HOLD: up_ready = 0. When the output register is free, move acc/acc_keep/acc_last into it, clear acc and cnt, and go to COLLECT.
- Lane order: the first beat of a word goes to lane 0 (LSBs). Unused lanes of a partial word are driven to 0, and their keep bits are 0.
- down_last equals the up_last of the completing beat. A word filled to ratio lanes without up_last has down_last = 0.
- Latency: the completing input beat appears on down_valid the next cycle. Sustained throughput is 1 output word per ratio input cycles.
- Boundary conditions:
  - up_last on lane 0: a 1-lane word, keep = 0...01.
  - up_last on lane ratio-1: a full word with down_last = 1.
  - down_ready held low: at most one word in the output register plus one completed word in HOLD; up_ready then stays 0 until space frees.
  - Output transfer in the same cycle as a completing beat: the new word loads; down_valid stays 1 with no bubble.
  - up_valid = 0 mid-word: partial contents are retained indefinitely. There is no timeout.
- Reset (rst = 1 at an edge):
  - State = COLLECT, cnt = 0.
  - acc, acc_keep and acc_last are cleared.
  - down_valid = 0, down_data = 0, down_keep = 0, down_last = 0.
  - up_ready = 1 from the first cycle after reset.
  - Reset mid-word or mid-HOLD discards all buffered data silently.

Decomposition:
- Shared package axis_pkg: state enum (COLLECT, HOLD) and a localparam function for the counter width (clog2 of ratio, minimum 1).
- Single module. The output register is simple enough to stay inline, so no sub-module is needed.

Test Plan:
- Defaults, down_ready = 1, beats 0x11, 0x22, 0x33, 0x44 back-to-back, last on 0x44 -> one cycle later down_data = 0x44332211, keep = 4'b1111, last = 1, up_ready never drops.
- Beats 0xA1, 0xA2 with last on 0xA2 -> down_data = 0x0000A2A1, keep = 4'b0011, last = 1. The next word starts in lane 0.
- Single beat 0x5C with last -> down_data = 0x0000005C, keep = 4'b0001, last = 1.
- down_ready = 0, stream 8 beats 0x01..0x08 (no last) -> word 0x04030201 held stable; after beat 0x08 state = HOLD, up_ready = 0. Raise down_ready -> 0x04030201 then 0x08070605 delivered in consecutive cycles; up_ready returns to 1.
- Continuous 16 beats with down_ready = 1 -> 4 words, down_valid pulses every 4th cycle, no input stalls.
- Assert rst after 2 beats of a word, then send 4 beats 0xB0..0xB3 -> only 0xB3B2B1B0 emerges; down_valid = 0 during and right after reset.
